// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide data types shared across pipeline stages.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t WORD_ZERO = '0;
  localparam word_t WORD_ONES = '1;

endpackage : cpu_types_pkg

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux selectors, fetch FSM states and instruction constants.
package data_path_muxs_pkg;

  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    PC4    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JR     = 2'd3
  } pc_mux_input_selection;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam word_t PC_STEP   = 32'd4;

  // Instruction fetches are word aligned; low address bits of any target are dropped.
  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(32'h3);
  endfunction

endpackage : data_path_muxs_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous clear, bubble insertion, load, or hold.
module if_id_reg
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
(
  input  logic  clk,
  input  logic  srst,
  input  logic  load,
  input  logic  bubble,
  input  word_t instr_next,
  input  word_t pc4_next,
  output word_t instr_reg,
  output word_t pc4_reg,
  output logic  valid_reg
);

  // A bubble only clears the instruction and valid bit; pc4 keeps its last value.
  always_ff @(posedge clk) begin
    if (srst) begin
      instr_reg <= NOP_INSTR;
      pc4_reg   <= WORD_ZERO;
      valid_reg <= 1'b0;
    end else if (bubble) begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (load) begin
      instr_reg <= instr_next;
      pc4_reg   <= pc4_next;
      valid_reg <= 1'b1;
    end
  end

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction fetch stage: BOOT/FETCH/HALTED FSM, PC with redirect, IF/ID register.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ihit,
  input  word_t                 iload,
  output logic                  iREN,
  output word_t                 iaddr,
  input  logic                  halt,
  input  logic                  stall,
  input  logic                  flush,
  input  pc_mux_input_selection PCSrc,
  input  word_t                 branch_target,
  input  word_t                 jump_target,
  input  word_t                 jr_target,
  output word_t                 instr_IF_ID,
  output word_t                 pc4_IF_ID,
  output logic                  valid_IF_ID,
  output logic [5:0]            opcode_IF_ID,
  output logic [5:0]            func_IF_ID,
  output logic [15:0]           imm16,
  output word_t                 fetch_count,
  output word_t                 wait_count
);

  fetch_state_t state_reg, state_next;
  word_t        pc_reg, pc_next;
  word_t        pc_plus4;
  word_t        redirect_target;
  logic         if_load, if_bubble;

  assign pc_plus4 = pc_reg + PC_STEP;

  always_comb begin
    redirect_target = pc_plus4;
    case (PCSrc)
      PC4:     redirect_target = pc_plus4;
      BRANCH:  redirect_target = branch_target;
      JUMP:    redirect_target = jump_target;
      JR:      redirect_target = jr_target;
      default: redirect_target = pc_plus4;
    endcase
    redirect_target = align_word(redirect_target);
  end

  // Priority inside the stage: halt > flush > stall > ihit.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if_load    = 1'b0;
    if_bubble  = 1'b0;
    if (halt) begin
      state_next = HALTED;
      if_bubble  = 1'b1;
    end else begin
      case (state_reg)
        BOOT: begin
          state_next = FETCH;
          if_bubble  = 1'b1;
        end
        FETCH: begin
          if (flush) begin
            if_bubble = 1'b1;
            pc_next   = redirect_target;
          end else if (!stall) begin
            if (ihit) begin
              if_load = 1'b1;
              pc_next = pc_plus4;
            end else begin
              if_bubble = 1'b1;
            end
          end
        end
        HALTED: begin
          if_bubble = 1'b1;
        end
        default: begin
          state_next = BOOT;
          if_bubble  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= BOOT;
      pc_reg    <= PC_INIT;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  assign iREN  = (state_reg == FETCH);
  assign iaddr = pc_reg;

  if_id_reg u_if_id_reg (
    .clk        (CLK),
    .srst       (RST),
    .load       (if_load),
    .bubble     (if_bubble),
    .instr_next (iload),
    .pc4_next   (pc_plus4),
    .instr_reg  (instr_IF_ID),
    .pc4_reg    (pc4_IF_ID),
    .valid_reg  (valid_IF_ID)
  );

  assign opcode_IF_ID = instr_IF_ID[31:26];
  assign func_IF_ID   = instr_IF_ID[5:0];
  assign imm16        = instr_IF_ID[15:0];

`ifdef FETCH_PERF_CNT_EN
  word_t fetch_count_reg;
  word_t wait_count_reg;
  logic  wait_cycle;

  // A wait cycle is any request cycle without returned data, whatever stall/flush do.
  assign wait_cycle = iREN && !ihit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_count_reg <= WORD_ZERO;
      wait_count_reg  <= WORD_ZERO;
    end else begin
      if (if_load && (fetch_count_reg != WORD_ONES)) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (wait_cycle && (wait_count_reg != WORD_ONES)) begin
        wait_count_reg <= wait_count_reg + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_reg;
  assign wait_count  = wait_count_reg;
`else
  assign fetch_count = WORD_ZERO;
  assign wait_count  = WORD_ZERO;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;

  localparam word_t PC_INIT_TB = 32'h0000_0040;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  ihit = 1'b0;
  word_t                 iload = '0;
  logic                  iREN;
  word_t                 iaddr;
  logic                  halt = 1'b0;
  logic                  stall = 1'b0;
  logic                  flush = 1'b0;
  pc_mux_input_selection PCSrc = PC4;
  word_t                 branch_target = '0;
  word_t                 jump_target = '0;
  word_t                 jr_target = '0;
  word_t                 instr_IF_ID;
  word_t                 pc4_IF_ID;
  logic                  valid_IF_ID;
  logic [5:0]            opcode_IF_ID;
  logic [5:0]            func_IF_ID;
  logic [15:0]           imm16;
  word_t                 fetch_count;
  word_t                 wait_count;

  int checks = 0;
  int failures = 0;

  // Behavioural model: "booting"/"halted" flags, PC, IF/ID contents, event counts.
  bit          m_booting, m_halted;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid;
  longint      m_fetches, m_waits;
  logic [31:0] pc_snap;

  fetch_stage #(.PC_INIT(PC_INIT_TB)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .halt(halt), .stall(stall), .flush(flush), .PCSrc(PCSrc),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .instr_IF_ID(instr_IF_ID), .pc4_IF_ID(pc4_IF_ID), .valid_IF_ID(valid_IF_ID),
    .opcode_IF_ID(opcode_IF_ID), .func_IF_ID(func_IF_ID), .imm16(imm16),
    .fetch_count(fetch_count), .wait_count(wait_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    if (RST) begin
      m_booting = 1; m_halted = 0; m_pc = PC_INIT_TB;
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_fetches = 0; m_waits = 0;
    end else begin
      if (!m_booting && !m_halted && !ihit && m_waits < 64'hFFFF_FFFF) m_waits++;
      if (halt) begin
        m_halted = 1; m_booting = 0; m_instr = 0; m_valid = 0;
      end else if (m_booting) begin
        m_booting = 0;
      end else if (m_halted) begin
        m_instr = 0; m_valid = 0;
      end else if (flush) begin
        case (PCSrc)
          BRANCH:  tgt = branch_target;
          JUMP:    tgt = jump_target;
          JR:      tgt = jr_target;
          default: tgt = m_pc + 4;
        endcase
        m_pc = {tgt[31:2], 2'b00};
        m_instr = 0; m_valid = 0;
      end else if (stall) begin
        // everything held
      end else if (ihit) begin
        m_instr = iload; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
        if (m_fetches < 64'hFFFF_FFFF) m_fetches++;
      end else begin
        m_instr = 0; m_valid = 0;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    logic [31:0] exp_fc, exp_wc;
`ifdef FETCH_PERF_CNT_EN
    exp_fc = m_fetches[31:0];
    exp_wc = m_waits[31:0];
`else
    exp_fc = 32'h0;
    exp_wc = 32'h0;
`endif
    chk({ctx, ".iREN"}, {31'b0, iREN}, {31'b0, !m_booting && !m_halted});
    chk({ctx, ".iaddr"}, iaddr, m_pc);
    chk({ctx, ".instr"}, instr_IF_ID, m_instr);
    chk({ctx, ".valid"}, {31'b0, valid_IF_ID}, {31'b0, m_valid});
    chk({ctx, ".opcode"}, {26'b0, opcode_IF_ID}, {26'b0, m_instr[31:26]});
    chk({ctx, ".func"}, {26'b0, func_IF_ID}, {26'b0, m_instr[5:0]});
    chk({ctx, ".imm16"}, {16'b0, imm16}, {16'b0, m_instr[15:0]});
    if (m_valid) chk({ctx, ".pc4"}, pc4_IF_ID, m_pc4);
    chk({ctx, ".fetch_count"}, fetch_count, exp_fc);
    chk({ctx, ".wait_count"}, wait_count, exp_wc);
  endtask

  task automatic cycle(input string ctx);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(ctx);
    $display("cyc t=%0t %s RST=%0b halt=%0b flush=%0b stall=%0b ihit=%0b -> iREN=%0b iaddr=%h valid=%0b instr=%h",
             $time, ctx, RST, halt, flush, stall, ihit, iREN, iaddr, valid_IF_ID, instr_IF_ID);
  endtask

  initial begin
    // Reset held for two cycles.
    RST = 1;
    cycle("reset0");
    cycle("reset1");
    chk("reset.iREN", {31'b0, iREN}, 32'h0);
    chk("reset.iaddr", iaddr, 32'h40);

    // Boot cycle, then fetching from PC_INIT.
    RST = 0; ihit = 1; iload = 32'h8C22_0004;
    cycle("boot");
    chk("boot.iREN", {31'b0, iREN}, 32'h1);
    chk("boot.iaddr", iaddr, 32'h40);

    cycle("first_hit");
    chk("hit.opcode", {26'b0, opcode_IF_ID}, 32'h23);
    chk("hit.imm16", {16'b0, imm16}, 32'h0004);
    chk("hit.pc4", pc4_IF_ID, 32'h44);
    chk("hit.valid", {31'b0, valid_IF_ID}, 32'h1);

    // Three miss cycles.
    ihit = 0;
    for (int i = 0; i < 3; i++) cycle("miss");
    chk("miss.iaddr", iaddr, 32'h44);
    chk("miss.valid", {31'b0, valid_IF_ID}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("miss.wait_count", wait_count, 32'd3);
`else
    chk("miss.wait_count", wait_count, 32'd0);
`endif

    // Flush overrides stall and ihit.
    ihit = 1; iload = 32'h1234_5678; stall = 1; flush = 1; PCSrc = JUMP; jump_target = 32'h100;
    cycle("flush_stall");
    chk("flush.iaddr", iaddr, 32'h100);
    chk("flush.valid", {31'b0, valid_IF_ID}, 32'h0);

    // Load one word, then stall with ihit high holds everything.
    flush = 0; stall = 0; iload = 32'h0042_1025;
    cycle("load");
    stall = 1; iload = 32'hDEAD_BEEF;
    cycle("stall");
    chk("stall.instr", instr_IF_ID, 32'h0042_1025);
    chk("stall.iaddr", iaddr, 32'h104);
    stall = 0;

    // Randomized traffic with occasional reset and halt.
    for (int i = 0; i < 500; i++) begin
      RST   = ($urandom_range(0, 49) == 0);
      halt  = ($urandom_range(0, 79) == 0);
      ihit  = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      PCSrc = pc_mux_input_selection'($urandom_range(0, 3));
      iload = $urandom();
      branch_target = $urandom();
      jump_target   = $urandom();
      jr_target     = $urandom();
      cycle("random");
    end

    // Reset arriving with ihit=1 mid-fetch drops the word.
    RST = 0; halt = 0; stall = 0; flush = 0; ihit = 1; iload = 32'hCAFE_0001;
    cycle("pre_reset");
    RST = 1; iload = 32'hCAFE_0002;
    cycle("reset_mid_fetch");
    chk("rst_mid.valid", {31'b0, valid_IF_ID}, 32'h0);
    chk("rst_mid.instr", instr_IF_ID, 32'h0);
    RST = 0;
    cycle("boot2");

    // Redirect to the top word (unaligned target bits ignored), then wrap.
    flush = 1; PCSrc = JR; jr_target = 32'hFFFF_FFFF;
    cycle("redirect_top");
    chk("top.iaddr", iaddr, 32'hFFFF_FFFC);
    flush = 0; ihit = 1; iload = 32'h2108_0001;
    cycle("wrap");
    chk("wrap.iaddr", iaddr, 32'h0);
    chk("wrap.pc4", pc4_IF_ID, 32'h0);
    chk("wrap.valid", {31'b0, valid_IF_ID}, 32'h1);

    // Halt with ihit asserted, then ten cycles of traffic that must be ignored.
    halt = 1; ihit = 1; iload = 32'h0BAD_F00D;
    cycle("halt");
    pc_snap = iaddr;
    chk("halt.iaddr", iaddr, 32'h0);
    halt = 0;
    for (int i = 0; i < 10; i++) begin
      ihit  = $urandom_range(0, 1);
      stall = $urandom_range(0, 1);
      flush = $urandom_range(0, 1);
      PCSrc = pc_mux_input_selection'($urandom_range(0, 3));
      jump_target = $urandom();
      iload = $urandom();
      cycle("halted");
      chk("halted.iREN", {31'b0, iREN}, 32'h0);
      chk("halted.valid", {31'b0, valid_IF_ID}, 32'h0);
      chk("halted.iaddr", iaddr, pc_snap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_stage
